// File: rtl/rv_muldiv.sv
// rv_muldiv: iterative RV32M multiply/divide unit, one result bit per cycle.
// Shift-add multiply over a 2*XLEN accumulator, restoring divide, tag passthrough.
module rv_muldiv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              r_state;
    logic [2:0]          r_f3;
    logic                r_sa;
    logic                r_sb;
    logic [CW-1:0]       r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_b;
    logic                r_resp_valid;
    logic [XLEN-1:0]     r_result;
    logic [TAG_W-1:0]    r_tag;

    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_b_zero;
    logic                w_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;
    logic [XLEN:0]       w_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_rem_sh;
    logic                w_ge;
    logic [XLEN-1:0]     w_rem_sub;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_q;
    logic [XLEN-1:0]     w_r;
    logic [XLEN-1:0]     w_final;

    assign req_ready   = (r_state == S_IDLE);
    assign resp_valid  = r_resp_valid;
    assign resp_result = r_result;
    assign resp_tag    = r_tag;

    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 only for MULH, DIV, REM
    assign w_sa = req_a[XLEN-1] & ((req_funct3 == 3'b001) | (req_funct3 == 3'b010) |
                                   (req_funct3[2] & ~req_funct3[0]));
    assign w_sb = req_b[XLEN-1] & ((req_funct3 == 3'b001) | (req_funct3[2] & ~req_funct3[0]));
    assign w_abs_a = w_sa ? -req_a : req_a;
    assign w_abs_b = w_sb ? -req_b : req_b;

    assign w_b_zero      = (req_b == '0);
    assign w_ovf         = req_funct3[2] & ~req_funct3[0] & (req_a == MIN) & (req_b == '1);
    assign w_special     = req_funct3[2] & (w_b_zero | w_ovf);
    assign w_special_res = w_b_zero ? (req_funct3[1] ? req_a : '1) : (req_funct3[1] ? '0 : MIN);

    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

    // the difference is below r_b whenever it is kept, so XLEN bits suffice
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_ge       = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub  = w_rem_sh[XLEN-1:0] - r_b;
    assign w_div_next = {w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], w_ge};

    assign w_prod  = (r_sa ^ r_sb) ? -w_mul_next : w_mul_next;
    assign w_q     = w_div_next[XLEN-1:0];
    assign w_r     = w_div_next[2*XLEN-1:XLEN];
    assign w_final = r_f3[2] ? (r_f3[1] ? (r_sa ? -w_r : w_r) : ((r_sa ^ r_sb) ? -w_q : w_q))
                             : ((r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_f3         <= '0;
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_b          <= '0;
            r_resp_valid <= 1'b0;
            r_result     <= '0;
            r_tag        <= '0;
        end else if (flush) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_f3    <= req_funct3;
                    r_sa    <= w_sa;
                    r_sb    <= w_sb;
                    r_tag   <= req_tag;
                    r_cnt   <= '0;
                    r_acc   <= {{XLEN{1'b0}}, w_abs_a};
                    r_b     <= w_abs_b;
                    r_state <= w_special ? S_DONE : S_BUSY;
                    if (w_special) r_result <= w_special_res;
                end
                S_BUSY: begin
                    r_acc <= r_f3[2] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state      <= S_DONE;
                        r_resp_valid <= 1'b1;
                        r_result     <= w_final;
                    end
                end
                S_DONE: begin
                    // special cases present their result one edge after entering DONE
                    if (!r_resp_valid) r_resp_valid <= 1'b1;
                    else if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
